// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch stage with a 1-entry skid register and the IF/ID pipeline register.
// Optional static prediction of unconditional B is enabled by defining FETCH_BPRED_EN.
module fetch_stage #(
    parameter int unsigned     PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            id_stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            if_valid,
    output logic [31:0]     if_instr,
    output logic [PC_W-1:0] if_pc,
    output logic [10:0]     if_op
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] PC_STEP    = PC_W'(4);
    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_pend_pc;
    logic            r_drop;
    logic [31:0]     r_skid_instr;
    logic [PC_W-1:0] r_skid_pc;
    logic            r_if_valid;
    logic [31:0]     r_if_instr;
    logic [PC_W-1:0] r_if_pc;
    logic [10:0]     r_if_op;

    logic [PC_W-1:0] w_redirect_pc;
    logic [PC_W-1:0] w_accept_pc;

    assign w_redirect_pc = redirect_pc & ALIGN_MASK;

`ifdef FETCH_BPRED_EN
    // Unconditional B is steered at accept time; a later redirect still wins.
    logic            w_is_b;
    logic [PC_W-1:0] w_b_off;
    assign w_is_b      = (imem_rdata[31:26] == 6'b000101);
    assign w_b_off     = {{(PC_W-28){imem_rdata[25]}}, imem_rdata[25:0], 2'b00};
    assign w_accept_pc = w_is_b ? (r_pend_pc + w_b_off) : r_pc;
`else
    assign w_accept_pc = r_pc;
`endif

    // Request is suppressed in the redirect cycle so the stale PC is never issued.
    assign imem_req  = rst_n && (r_state == S_FETCH) && !redirect;
    assign imem_addr = r_pc;

    assign if_valid = r_if_valid;
    assign if_instr = r_if_instr;
    assign if_pc    = r_if_pc;
    assign if_op    = r_if_op;

    // Skid occupancy is implied by S_HOLD, so no separate valid bit is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC;
            r_pend_pc    <= '0;
            r_drop       <= 1'b0;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
            r_if_valid   <= 1'b0;
            r_if_instr   <= '0;
            r_if_pc      <= '0;
            r_if_op      <= '0;
        end else if (redirect) begin
            r_pc       <= w_redirect_pc;
            r_if_valid <= 1'b0;
            case (r_state)
                S_WAIT: begin
                    if (imem_rvalid) begin
                        r_drop  <= 1'b0;
                        r_state <= S_FETCH;
                    end else begin
                        r_drop  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (!id_stall) begin
                        r_if_valid <= 1'b0;
                    end
                    if (imem_gnt) begin
                        r_pend_pc <= r_pc;
                        r_pc      <= r_pc + PC_STEP;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!id_stall) begin
                        r_if_valid <= 1'b0;
                    end
                    if (imem_rvalid) begin
                        if (r_drop) begin
                            r_drop  <= 1'b0;
                            r_state <= S_FETCH;
                        end else if (!id_stall) begin
                            r_if_valid <= 1'b1;
                            r_if_instr <= imem_rdata;
                            r_if_pc    <= r_pend_pc;
                            r_if_op    <= imem_rdata[31:21];
                            r_pc       <= w_accept_pc;
                            r_state    <= S_FETCH;
                        end else begin
                            r_skid_instr <= imem_rdata;
                            r_skid_pc    <= r_pend_pc;
                            r_pc         <= w_accept_pc;
                            r_state      <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!id_stall) begin
                        r_if_valid <= 1'b1;
                        r_if_instr <= r_skid_instr;
                        r_if_pc    <= r_skid_pc;
                        r_if_op    <= r_skid_instr[31:21];
                        r_state    <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, random traffic against a
// transaction-level model, and a PC wrap check on a second instance.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        id_stall = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic [10:0] if_op;

    logic        rst2_n = 1'b0;
    logic        req2;
    logic [63:0] addr2;
    logic        gnt2 = 1'b0;
    logic        rv2 = 1'b0;
    logic        v2;
    logic [31:0] instr2;
    logic [63:0] pc2;
    logic [10:0] op2;

    always #5 clk = ~clk;

    fetch_stage #(.PC_W(64), .RESET_PC(64'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_stall(id_stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_op(if_op)
    );

    fetch_stage #(.PC_W(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst2_n),
        .imem_req(req2), .imem_addr(addr2), .imem_gnt(gnt2),
        .imem_rvalid(rv2), .imem_rdata(32'hF840_0000),
        .id_stall(1'b0), .redirect(1'b0), .redirect_pc(64'h0),
        .if_valid(v2), .if_instr(instr2), .if_pc(pc2), .if_op(op2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Transaction-level reference: one outstanding read, at most one held word.
    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } word_t;

    logic [63:0] m_pc = 64'h0;
    bit          m_out = 0;
    logic [63:0] m_out_pc = 64'h0;
    bit          m_drop = 0;
    word_t       m_skid[$];
    bit          m_v = 0;
    word_t       m_if = '{instr: 32'h0, pc: 64'h0};

    logic        cap_req;
    logic [63:0] cap_addr;

    task automatic do_cycle(input logic g, input logic rv, input logic [31:0] rd,
                            input logic st, input logic re, input logic [63:0] rpc);
        bit          exp_req;
        bit          got;
        word_t       w;
        longint      off;
        @(negedge clk);
        imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
        id_stall = st; redirect = re; redirect_pc = rpc;
        #1;
        exp_req  = !m_out && (m_skid.size() == 0) && !re;
        cap_req  = imem_req;
        cap_addr = imem_addr;
        chk("req", 64'(imem_req), 64'(exp_req));
        if (exp_req) chk("addr", imem_addr, m_pc);
        @(posedge clk);
        if (re) begin
            m_pc = rpc & ~64'd3;
            m_v  = 0;
            m_skid.delete();
            if (m_out) begin
                if (rv) begin
                    m_out  = 0;
                    m_drop = 0;
                end else begin
                    m_drop = 1;
                end
            end
        end else begin
            got = 0;
            if (m_out && rv) begin
                m_out = 0;
                if (m_drop) begin
                    m_drop = 0;
                end else begin
                    w.instr = rd;
                    w.pc    = m_out_pc;
`ifdef FETCH_BPRED_EN
                    if (rd[31:26] == 6'b000101) begin
                        off  = longint'($signed(rd[25:0]));
                        m_pc = w.pc + 64'(off * 4);
                    end
`endif
                    if (st) m_skid.push_back(w);
                    else begin
                        m_if = w;
                        got  = 1;
                    end
                end
            end else if (m_skid.size() != 0 && !st) begin
                m_if = m_skid.pop_front();
                got  = 1;
            end
            if (!st) m_v = got;
            if (exp_req && g) begin
                m_out    = 1;
                m_out_pc = m_pc;
                m_pc     = m_pc + 64'd4;
            end
        end
        #1;
        chk("if_valid", 64'(if_valid), 64'(m_v));
        chk("if_pc", if_pc, m_if.pc);
        chk("if_instr", 64'(if_instr), 64'(m_if.instr));
        chk("if_op", 64'(if_op), 64'(m_if.instr[31:21]));
    endtask

    typedef struct {
        logic        g, rv;
        logic [31:0] rd;
        logic        st, re;
        logic [63:0] rpc;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_v;
        logic [63:0] e_pc;
        logic [10:0] e_op;
    } vec_t;

    function automatic vec_t mk(input logic g, input logic rv, input logic [31:0] rd,
                                input logic st, input logic re, input logic [63:0] rpc,
                                input logic e_req, input logic [63:0] e_addr,
                                input logic e_v, input logic [63:0] e_pc, input logic [10:0] e_op);
        vec_t v;
        v.g = g; v.rv = rv; v.rd = rd; v.st = st; v.re = re; v.rpc = rpc;
        v.e_req = e_req; v.e_addr = e_addr; v.e_v = e_v; v.e_pc = e_pc; v.e_op = e_op;
        return v;
    endfunction

    localparam logic [31:0] W0 = 32'hF840_0000;  // LDUR, op 0x7C2
    localparam logic [31:0] W1 = 32'h8B02_0020;  // op 0x458
    localparam logic [31:0] W2 = 32'hCB00_0000;  // op 0x658
    localparam logic [31:0] W3 = 32'hAA00_0000;  // op 0x550
    localparam logic [31:0] BW = 32'h1400_0004;  // B +16, op 0x0A0
`ifdef FETCH_BPRED_EN
    localparam logic [63:0] BR_NEXT = 64'h30;
`else
    localparam logic [63:0] BR_NEXT = 64'h24;
`endif

    vec_t vecs[27];

    initial begin
        vecs[0]  = mk(1, 0, 0,  0, 0, 0,      1, 64'h0,   0, 64'h0,   11'h000);
        vecs[1]  = mk(0, 1, W0, 0, 0, 0,      0, 64'h0,   1, 64'h0,   11'h7C2);
        vecs[2]  = mk(1, 0, 0,  0, 0, 0,      1, 64'h4,   0, 64'h0,   11'h7C2);
        vecs[3]  = mk(0, 1, W1, 0, 0, 0,      0, 64'h0,   1, 64'h4,   11'h458);
        vecs[4]  = mk(1, 0, 0,  0, 0, 0,      1, 64'h8,   0, 64'h4,   11'h458);
        vecs[5]  = mk(0, 1, W2, 0, 0, 0,      0, 64'h0,   1, 64'h8,   11'h658);
        vecs[6]  = mk(1, 0, 0,  1, 0, 0,      1, 64'hC,   1, 64'h8,   11'h658);
        vecs[7]  = mk(0, 1, W3, 1, 0, 0,      0, 64'h0,   1, 64'h8,   11'h658);
        vecs[8]  = mk(1, 0, 0,  1, 0, 0,      0, 64'h0,   1, 64'h8,   11'h658);
        vecs[9]  = mk(0, 0, 0,  0, 0, 0,      0, 64'h0,   1, 64'hC,   11'h550);
        vecs[10] = mk(1, 0, 0,  0, 0, 0,      1, 64'h10,  0, 64'hC,   11'h550);
        vecs[11] = mk(0, 0, 0,  0, 1, 64'h103, 0, 64'h0,  0, 64'hC,   11'h550);
        vecs[12] = mk(0, 1, W1, 0, 0, 0,      0, 64'h0,   0, 64'hC,   11'h550);
        vecs[13] = mk(1, 0, 0,  0, 0, 0,      1, 64'h100, 0, 64'hC,   11'h550);
        vecs[14] = mk(0, 1, W0, 0, 0, 0,      0, 64'h0,   1, 64'h100, 11'h7C2);
        vecs[15] = mk(1, 0, 0,  0, 0, 0,      1, 64'h104, 0, 64'h100, 11'h7C2);
        vecs[16] = mk(0, 1, W2, 0, 1, 64'h200, 0, 64'h0,  0, 64'h100, 11'h7C2);
        vecs[17] = mk(1, 0, 0,  0, 0, 0,      1, 64'h200, 0, 64'h100, 11'h7C2);
        vecs[18] = mk(0, 1, W3, 0, 0, 0,      0, 64'h0,   1, 64'h200, 11'h550);
        vecs[19] = mk(1, 0, 0,  0, 1, 64'h300, 0, 64'h0,  0, 64'h200, 11'h550);
        vecs[20] = mk(1, 0, 0,  0, 0, 0,      1, 64'h300, 0, 64'h200, 11'h550);
        vecs[21] = mk(0, 1, W0, 0, 0, 0,      0, 64'h0,   1, 64'h300, 11'h7C2);
        vecs[22] = mk(0, 0, 0,  1, 1, 64'h20, 0, 64'h0,   0, 64'h300, 11'h7C2);
        vecs[23] = mk(1, 0, 0,  0, 0, 0,      1, 64'h20,  0, 64'h300, 11'h7C2);
        vecs[24] = mk(0, 1, BW, 0, 0, 0,      0, 64'h0,   1, 64'h20,  11'h0A0);
        vecs[25] = mk(1, 0, 0,  0, 0, 0,      1, BR_NEXT, 0, 64'h20,  11'h0A0);
        vecs[26] = mk(0, 1, W1, 0, 0, 0,      0, 64'h0,   1, BR_NEXT, 11'h458);

        #3;
        chk("rst_req", 64'(imem_req), 64'h0);
        chk("rst_addr", imem_addr, 64'h0);
        chk("rst_valid", 64'(if_valid), 64'h0);
        chk("rst_instr", 64'(if_instr), 64'h0);
        chk("rst_pc", if_pc, 64'h0);
        chk("rst_op", 64'(if_op), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            do_cycle(vecs[i].g, vecs[i].rv, vecs[i].rd, vecs[i].st, vecs[i].re, vecs[i].rpc);
            chk($sformatf("vec%0d_req", i), 64'(cap_req), 64'(vecs[i].e_req));
            if (vecs[i].e_req) chk($sformatf("vec%0d_addr", i), cap_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d_valid", i), 64'(if_valid), 64'(vecs[i].e_v));
            chk($sformatf("vec%0d_pc", i), if_pc, vecs[i].e_pc);
            chk($sformatf("vec%0d_op", i), 64'(if_op), 64'(vecs[i].e_op));
            $display("vec %0d: req=%0b addr=%h valid=%0b pc=%h op=%h",
                     i, cap_req, cap_addr, if_valid, if_pc, if_op);
        end

        for (int i = 0; i < 4000; i++) begin
            logic        g, rv, st, re;
            logic [31:0] rd;
            logic [63:0] rpc;
            g   = 1'($urandom_range(0, 1));
            rv  = m_out ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
            rd  = $urandom;
            if ($urandom_range(0, 7) == 0) rd[31:26] = 6'b000101;
            st  = ($urandom_range(0, 3) == 0);
            re  = ($urandom_range(0, 15) == 0);
            rpc = {$urandom, $urandom};
            do_cycle(g, rv, rd, st, re, rpc);
        end
        $display("random phase: 4000 cycles applied");

        // PC wrap on the second instance.
        @(negedge clk);
        rst2_n = 1'b1;
        gnt2 = 1'b1;
        #1;
        chk("wrap_req0", 64'(req2), 64'h1);
        chk("wrap_addr0", addr2, 64'hFFFF_FFFF_FFFF_FFFC);
        @(negedge clk);
        gnt2 = 1'b0; rv2 = 1'b1;
        #1;
        chk("wrap_wait_req", 64'(req2), 64'h0);
        @(negedge clk);
        rv2 = 1'b0;
        #1;
        chk("wrap_req1", 64'(req2), 64'h1);
        chk("wrap_addr1", addr2, 64'h0);
        chk("wrap_valid", 64'(v2), 64'h1);
        chk("wrap_pc", pc2, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_op", 64'(op2), 64'h7C2);
        $display("wrap: addr=%h if_pc=%h instr=%h", addr2, pc2, instr2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
